// File: rtl/mic_track_pkg.sv
// ---------------------------------------------------------------------------
// mic_track_pkg
// Shared definitions for the microphone direction-tracking datapath.
//   AMP_W / DIFF_W   : amplitude width and width of the signed left-right delta
//   DIR_*            : direction codes handed to the tracking FSM
//   trackState_e     : scheduler state encoding (IDLE, COLLECT, DECIDE, PRESENT)
//   ampDiff()        : 17-bit two's-complement left minus right
//   classifyPair()   : turns a window pair into a direction code
// ---------------------------------------------------------------------------
package mic_track_pkg;

   localparam int AMP_W  = 16;
   localparam int DIFF_W = 17;

   localparam logic [1:0] DIR_CENTER = 2'b00;
   localparam logic [1:0] DIR_LEFT   = 2'b01;
   localparam logic [1:0] DIR_RIGHT  = 2'b10;
   localparam logic [1:0] DIR_SILENT = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COLLECT = 2'b01,
      DECIDE  = 2'b10,
      PRESENT = 2'b11
   } trackState_e;

   // Both amplitudes are zero-extended first so the subtraction can never wrap;
   // the MSB of the result is then a true sign bit.
   function automatic logic [DIFF_W-1:0] ampDiff(input logic [AMP_W-1:0] leftAmp,
                                                 input logic [AMP_W-1:0] rightAmp);
      return {1'b0, leftAmp} - {1'b0, rightAmp};
   endfunction

   // Silence is checked before the deadband so an all-zero pair is never CENTER.
   // The magnitude of a 17-bit delta of two 16-bit values always fits in 17 bits.
   function automatic logic [1:0] classifyPair(input logic [AMP_W-1:0]  leftAmp,
                                               input logic [AMP_W-1:0]  rightAmp,
                                               input logic [DIFF_W-1:0] deadband);
      logic [DIFF_W-1:0] delta;
      logic [DIFF_W-1:0] mag;
      delta = ampDiff(leftAmp, rightAmp);
      mag   = delta[DIFF_W-1] ? (~delta + DIFF_W'(1)) : delta;
      if ((leftAmp == '0) && (rightAmp == '0)) begin
         return DIR_SILENT;
      end else if (mag <= deadband) begin
         return DIR_CENTER;
      end else if (!delta[DIFF_W-1]) begin
         return DIR_LEFT;
      end else begin
         return DIR_RIGHT;
      end
   endfunction

endpackage

// File: rtl/amp_capture.sv
// ---------------------------------------------------------------------------
// amp_capture
// One side of the scheduler: detects a new window from the amplitude unit's
// done level, latches the amplitude and keeps a "captured" flag.
//   clock, reset     : system clock, synchronous active-high reset
//   done_i, amp_i    : done level and amplitude from the amplitude unit
//   captureEn_i      : scheduler is willing to take a window this cycle
//   clear_i          : drop the captured flag (a capture in the same cycle wins)
//   windowEdge_o     : rising edge of done_i, independent of captureEn_i
//   amp_o            : most recently captured amplitude
//   captured_o       : captured flag (registered)
//   capturedNext_o   : value the flag takes at the next clock edge
// ---------------------------------------------------------------------------
module amp_capture
   import mic_track_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             done_i,
   input  logic [AMP_W-1:0] amp_i,
   input  logic             captureEn_i,
   input  logic             clear_i,
   output logic             windowEdge_o,
   output logic [AMP_W-1:0] amp_o,
   output logic             captured_o,
   output logic             capturedNext_o
);

   logic             done_q;
   logic             captured_q, captured_d;
   logic [AMP_W-1:0] amp_q, amp_d;

   assign windowEdge_o = done_i & ~done_q;

   // A fresh window always beats a clear, so an edge arriving together with an
   // acknowledge is kept. A repeat edge simply overwrites the older amplitude.
   always_comb begin
      captured_d = captured_q;
      amp_d      = amp_q;
      if (captureEn_i && windowEdge_o) begin
         captured_d = 1'b1;
         amp_d      = amp_i;
      end else if (clear_i) begin
         captured_d = 1'b0;
      end
   end

   // done_q follows done_i regardless of scheduler state, so a done level that
   // is already high when scheduling starts is never mistaken for a new window.
   always_ff @(posedge clock) begin
      if (reset) begin
         done_q     <= 1'b0;
         captured_q <= 1'b0;
         amp_q      <= '0;
      end else begin
         done_q     <= done_i;
         captured_q <= captured_d;
         amp_q      <= amp_d;
      end
   end

   assign amp_o          = amp_q;
   assign captured_o     = captured_q;
   assign capturedNext_o = captured_d;

endmodule

// File: rtl/mic_pair_scheduler.sv
// ---------------------------------------------------------------------------
// mic_pair_scheduler
// Pairs one completed window from each microphone, compares the amplitudes and
// presents a single direction decision per pair to the tracking FSM.
//   clock, reset            : sole clock, synchronous active-high reset
//   enable                  : 1 = scheduling active, 0 = idle with captures cleared
//   left_done / left_amp    : left amplitude unit (rising done = new window)
//   right_done / right_amp  : right amplitude unit
//   ack                     : consumer takes the presented decision
//   valid                   : decision outputs stable, held until ack
//   direction               : 00 CENTER, 01 LEFT, 10 RIGHT, 11 SILENT
//   diff                    : signed left_amp - right_amp of the decided pair
//   timeout_err             : one-cycle pulse when a half pair is discarded
//   overrun                 : sticky, a window arrived while a decision waited
// ---------------------------------------------------------------------------
module mic_pair_scheduler
   import mic_track_pkg::*;
#(
   parameter int DEADBAND = 500,
   parameter int TIMEOUT  = 50000,
   parameter int TMO_W    = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              left_done,
   input  logic [AMP_W-1:0]  left_amp,
   input  logic              right_done,
   input  logic [AMP_W-1:0]  right_amp,
   input  logic              ack,
   output logic              valid,
   output logic [1:0]        direction,
   output logic [DIFF_W-1:0] diff,
   output logic              timeout_err,
   output logic              overrun
);

   trackState_e       state_q, state_d;
   logic [TMO_W-1:0]  timeoutCnt_q, timeoutCnt_d;
   logic              valid_q, valid_d;
   logic [1:0]        direction_q, direction_d;
   logic [DIFF_W-1:0] diff_q, diff_d;
   logic              timeoutErr_q, timeoutErr_d;
   logic              overrun_q, overrun_d;

   logic              leftEdge, rightEdge;
   logic [AMP_W-1:0]  leftAmpCap, rightAmpCap;
   logic              leftFlag, rightFlag;
   logic              leftFlagNext, rightFlagNext;
   logic              inCollect, inPresent, ackTaken;
   logic              captureEn, clearFlags;
   logic              oneSided, missingEdge, timeoutHit;

   // Windows are accepted while collecting, and also in the very cycle a
   // presented decision is acknowledged so that window is not lost.
   // Flags are dropped when scheduling stops, when the decision is taken and
   // when a lone half pair has waited too long.
   always_comb begin
      inCollect   = (state_q == COLLECT);
      inPresent   = (state_q == PRESENT);
      ackTaken    = inPresent & ack;
      captureEn   = enable & (inCollect | ackTaken);
      oneSided    = inCollect & (leftFlag ^ rightFlag);
      missingEdge = (leftFlag & rightEdge) | (rightFlag & leftEdge);
      timeoutHit  = oneSided & ~missingEdge &
                    (timeoutCnt_q == TMO_W'(TIMEOUT - 1));
      clearFlags  = ~enable | ackTaken | timeoutHit;
   end

   amp_capture uLeft (
      .clock          (clock),
      .reset          (reset),
      .done_i         (left_done),
      .amp_i          (left_amp),
      .captureEn_i    (captureEn),
      .clear_i        (clearFlags),
      .windowEdge_o   (leftEdge),
      .amp_o          (leftAmpCap),
      .captured_o     (leftFlag),
      .capturedNext_o (leftFlagNext)
   );

   amp_capture uRight (
      .clock          (clock),
      .reset          (reset),
      .done_i         (right_done),
      .amp_i          (right_amp),
      .captureEn_i    (captureEn),
      .clear_i        (clearFlags),
      .windowEdge_o   (rightEdge),
      .amp_o          (rightAmpCap),
      .captured_o     (rightFlag),
      .capturedNext_o (rightFlagNext)
   );

   // Next-state logic. COLLECT looks at the flags as they will be after this
   // edge, so the cycle that completes a pair is already the step into DECIDE.
   // Dropping enable overrides everything and parks the scheduler in IDLE.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = COLLECT;
            COLLECT: if (leftFlagNext && rightFlagNext) state_d = DECIDE;
            DECIDE:  state_d = PRESENT;
            PRESENT: if (ack) state_d = COLLECT;
            default: state_d = IDLE;
         endcase
      end
   end

   // The pairing timer only runs while exactly one side is waiting. It is not
   // restarted by a repeat window on the waiting side, and a window on the
   // missing side in the expiry cycle completes the pair instead of timing out.
   always_comb begin
      timeoutCnt_d = '0;
      if (enable && oneSided && !missingEdge && !timeoutHit) begin
         timeoutCnt_d = timeoutCnt_q + TMO_W'(1);
      end
   end

   // Decision and status outputs. direction/diff are only rewritten in DECIDE
   // and otherwise keep their value, even across a disable. valid simply
   // mirrors being in PRESENT. A window edge that arrives while a decision is
   // waiting and not being acknowledged marks an overrun until disabled.
   always_comb begin
      direction_d  = direction_q;
      diff_d       = diff_q;
      valid_d      = (state_d == PRESENT);
      timeoutErr_d = timeoutHit;
      overrun_d    = overrun_q;
      if (enable && (state_q == DECIDE)) begin
         direction_d = classifyPair(leftAmpCap, rightAmpCap, DIFF_W'(DEADBAND));
         diff_d      = ampDiff(leftAmpCap, rightAmpCap);
      end
      if (!enable) begin
         overrun_d = 1'b0;
      end else if (inPresent && !ack && (leftEdge || rightEdge)) begin
         overrun_d = 1'b1;
      end
   end

   // All scheduler registers share the one synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         timeoutCnt_q <= '0;
         valid_q      <= 1'b0;
         direction_q  <= DIR_CENTER;
         diff_q       <= '0;
         timeoutErr_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         timeoutCnt_q <= timeoutCnt_d;
         valid_q      <= valid_d;
         direction_q  <= direction_d;
         diff_q       <= diff_d;
         timeoutErr_q <= timeoutErr_d;
         overrun_q    <= overrun_d;
      end
   end

   assign valid       = valid_q;
   assign direction   = direction_q;
   assign diff        = diff_q;
   assign timeout_err = timeoutErr_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_mic_pair_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mic_pair_scheduler
// Directed bench for mic_pair_scheduler. Inputs change 1 time unit after the
// rising clock edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_mic_pair_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        leftDone;
   logic [15:0] leftAmp;
   logic        rightDone;
   logic [15:0] rightAmp;
   logic        ack;
   logic        valid;
   logic [1:0]  direction;
   logic [16:0] diff;
   logic        timeoutErr;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   mic_pair_scheduler dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .left_done   (leftDone),
      .left_amp    (leftAmp),
      .right_done  (rightDone),
      .right_amp   (rightAmp),
      .ack         (ack),
      .valid       (valid),
      .direction   (direction),
      .diff        (diff),
      .timeout_err (timeoutErr),
      .overrun     (overrun)
   );

   // 10-unit clock period
   always #5 clock = ~clock;

   // Advance one cycle and land just after the rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive all data-path inputs at once
   task automatic applyStimulus(input logic le, input logic [15:0] la,
                                input logic re, input logic [15:0] ra,
                                input logic ak);
      leftDone  = le;
      leftAmp   = la;
      rightDone = re;
      rightAmp  = ra;
      ack       = ak;
   endtask

   // One-cycle rising done on the selected sides, then both done levels low
   task automatic pulse(input logic le, input logic [15:0] la,
                        input logic re, input logic [15:0] ra);
      applyStimulus(le, la, re, ra, 1'b0);
      tick();
      leftDone  = 1'b0;
      rightDone = 1'b0;
   endtask

   // One comparison: counted, and reported on mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Acknowledge the presented decision for one cycle
   task automatic acknowledge();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   initial begin
      int timeoutPulses;
      int validSeen;
      int firstPulse;

      reset  = 1'b1;
      enable = 1'b0;
      applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
      tick();
      tick();
      $display("[TB] reset state");
      checkOutput("rst_valid", 32'(valid), 32'd0);
      checkOutput("rst_direction", 32'(direction), 32'd0);
      checkOutput("rst_diff", 32'(diff), 32'd0);
      checkOutput("rst_timeout_err", 32'(timeoutErr), 32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);

      reset  = 1'b0;
      enable = 1'b1;
      tick();
      tick();

      // Left first, right 40 cycles later
      $display("[TB] staggered pair L=9000 R=6000");
      pulse(1'b1, 16'd9000, 1'b0, 16'd0);
      repeat (39) tick();
      pulse(1'b0, 16'd9000, 1'b1, 16'd6000);
      checkOutput("stag_valid_n1", 32'(valid), 32'd0);
      tick();
      checkOutput("stag_valid_n2", 32'(valid), 32'd1);
      checkOutput("stag_direction", 32'(direction), 32'h1);
      checkOutput("stag_diff", 32'(diff), 32'(17'd3000));
      acknowledge();
      checkOutput("stag_valid_after_ack", 32'(valid), 32'd0);

      // Simultaneous edges inside the deadband
      $display("[TB] simultaneous L=7000 R=7400");
      pulse(1'b1, 16'd7000, 1'b1, 16'd7400);
      tick();
      checkOutput("sim400_valid", 32'(valid), 32'd1);
      checkOutput("sim400_direction", 32'(direction), 32'h0);
      checkOutput("sim400_diff", 32'(diff), 32'(17'h1FE70));
      acknowledge();

      $display("[TB] simultaneous L=7000 R=7600");
      pulse(1'b1, 16'd7000, 1'b1, 16'd7600);
      tick();
      checkOutput("sim600_direction", 32'(direction), 32'h2);
      checkOutput("sim600_diff", 32'(diff), 32'(17'h1FDA8));
      acknowledge();

      $display("[TB] silence and deadband edges");
      pulse(1'b1, 16'd0, 1'b1, 16'd0);
      tick();
      checkOutput("zero_direction", 32'(direction), 32'h3);
      checkOutput("zero_diff", 32'(diff), 32'd0);
      acknowledge();
      pulse(1'b1, 16'd0, 1'b1, 16'd501);
      tick();
      checkOutput("r501_direction", 32'(direction), 32'h2);
      checkOutput("r501_diff", 32'(diff), 32'(17'h1FE0B));
      acknowledge();
      pulse(1'b1, 16'd500, 1'b1, 16'd0);
      tick();
      checkOutput("l500_direction", 32'(direction), 32'h0);
      checkOutput("l500_diff", 32'(diff), 32'(17'h1F4));
      acknowledge();

      // Lone left window must be discarded after the pairing timeout
      $display("[TB] one-sided timeout");
      pulse(1'b1, 16'd1234, 1'b0, 16'd0);
      timeoutPulses = 0;
      validSeen     = 0;
      firstPulse    = -1;
      for (int i = 0; i < 50100; i++) begin
         tick();
         if (timeoutErr) begin
            timeoutPulses++;
            if (firstPulse < 0) firstPulse = i;
         end
         if (valid) validSeen++;
      end
      checkOutput("tmo_pulses", 32'(timeoutPulses), 32'd1);
      checkOutput("tmo_no_valid", 32'(validSeen), 32'd0);
      checkOutput("tmo_window", 32'((firstPulse >= 49995) && (firstPulse <= 50005)), 32'd1);
      pulse(1'b1, 16'd100, 1'b1, 16'd5000);
      tick();
      checkOutput("post_tmo_valid", 32'(valid), 32'd1);
      checkOutput("post_tmo_direction", 32'(direction), 32'h2);
      checkOutput("post_tmo_diff", 32'(diff), 32'(17'h1ECDC));
      acknowledge();

      // Edge coinciding with ack is captured and is not an overrun
      $display("[TB] edge with ack");
      pulse(1'b1, 16'd3000, 1'b1, 16'd1000);
      tick();
      checkOutput("ackedge_pre_direction", 32'(direction), 32'h1);
      checkOutput("ackedge_pre_diff", 32'(diff), 32'(17'd2000));
      applyStimulus(1'b1, 16'd4000, 1'b0, 16'd1000, 1'b1);
      tick();
      applyStimulus(1'b0, 16'd4000, 1'b0, 16'd1000, 1'b0);
      checkOutput("ackedge_overrun", 32'(overrun), 32'd0);
      checkOutput("ackedge_valid", 32'(valid), 32'd0);
      pulse(1'b0, 16'd4000, 1'b1, 16'd4000);
      tick();
      checkOutput("ackedge_pair_valid", 32'(valid), 32'd1);
      checkOutput("ackedge_pair_direction", 32'(direction), 32'h0);
      checkOutput("ackedge_pair_diff", 32'(diff), 32'd0);

      // Edge while the decision waits un-acknowledged
      $display("[TB] overrun");
      pulse(1'b1, 16'd9999, 1'b0, 16'd4000);
      checkOutput("ovr_overrun", 32'(overrun), 32'd1);
      checkOutput("ovr_valid", 32'(valid), 32'd1);
      checkOutput("ovr_direction", 32'(direction), 32'h0);
      checkOutput("ovr_diff", 32'(diff), 32'd0);
      acknowledge();

      // Disable mid-collect, re-enable with right done already high
      $display("[TB] enable drop");
      pulse(1'b1, 16'd2000, 1'b0, 16'd0);
      enable = 1'b0;
      applyStimulus(1'b0, 16'd2000, 1'b1, 16'd7777, 1'b0);
      tick();
      checkOutput("dis_overrun", 32'(overrun), 32'd0);
      checkOutput("dis_valid", 32'(valid), 32'd0);
      tick();
      enable = 1'b1;
      repeat (4) tick();
      checkOutput("reen_no_valid", 32'(valid), 32'd0);
      leftDone = 1'b1;
      leftAmp  = 16'd2000;
      tick();
      leftDone = 1'b0;
      tick();
      tick();
      checkOutput("reen_no_spurious", 32'(valid), 32'd0);
      rightDone = 1'b0;
      tick();
      pulse(1'b0, 16'd2000, 1'b1, 16'd2600);
      tick();
      checkOutput("reen_valid", 32'(valid), 32'd1);
      checkOutput("reen_direction", 32'(direction), 32'h2);
      checkOutput("reen_diff", 32'(diff), 32'(17'h1FDA8));

      // Reset while presenting clears every output
      $display("[TB] reset in PRESENT");
      reset = 1'b1;
      tick();
      checkOutput("rstp_valid", 32'(valid), 32'd0);
      checkOutput("rstp_direction", 32'(direction), 32'd0);
      checkOutput("rstp_diff", 32'(diff), 32'd0);
      checkOutput("rstp_overrun", 32'(overrun), 32'd0);
      checkOutput("rstp_timeout_err", 32'(timeoutErr), 32'd0);
      reset = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
